// File: rtl/hqc_msg_serializer.sv
// hqc_msg_serializer
//   Takes a decoded HQC message (PARAM_K bytes, delivered in parallel on a
//   one-cycle msg_valid_i pulse) and streams it out as NBEATS beats of DOUT_W
//   bits with a valid/ready handshake. The data is sent LSB byte first. The
//   final beat is zero-filled above the message and carries a partial keep mask.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active-low
//   msg_i        decoded message m' (DIN_W bits)
//   msg_valid_i  one-cycle pulse, msg_i valid
//   clear_i      synchronous clear of overrun_o
//   m_data_o     stream beat data
//   m_keep_o     byte-valid mask for the current beat
//   m_last_o     final beat of the message
//   m_valid_o    beat valid
//   m_ready_i    consumer ready
//   busy_o       a message is held or being sent
//   done_o       one-cycle pulse after the last beat has been accepted
//   overrun_o    sticky: a message arrived while busy and was dropped
module hqc_msg_serializer #(
  parameter int PARAM_SECURITY = 128,
  parameter int PARAM_K        = (PARAM_SECURITY == 256) ? 32 :
                                 (PARAM_SECURITY == 192) ? 24 : 16,
  parameter int DIN_W          = 8 * PARAM_K,
  parameter int DOUT_W         = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DIN_W-1:0]    msg_i,
  input  logic                msg_valid_i,
  input  logic                clear_i,
  output logic [DOUT_W-1:0]   m_data_o,
  output logic [DOUT_W/8-1:0] m_keep_o,
  output logic                m_last_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o
);

  localparam int NBEATS     = (DIN_W + DOUT_W - 1) / DOUT_W;
  localparam int LAST_BYTES = PARAM_K - (NBEATS - 1) * DOUT_W / 8;
  localparam int KEEP_W     = DOUT_W / 8;
  localparam int CNT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PAD_W      = NBEATS * DOUT_W;

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [KEEP_W-1:0] FULL_KEEP = '1;
  localparam logic [KEEP_W-1:0] LAST_KEEP = FULL_KEEP >> (KEEP_W - LAST_BYTES);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIN_W-1:0]   cap_q, cap_d;
  logic               done_q, done_d;
  logic               ovr_q, ovr_d;

  logic               send;
  logic               is_last;
  logic               hs;
  logic [PAD_W-1:0]   cap_pad;
  logic [DOUT_W-1:0]  beat_data;

  assign send    = (state_q == SEND);
  assign is_last = (cnt_q == LAST_BEAT);
  assign hs      = send && m_ready_i;

  // Zero-extend the capture register to a whole number of beats so the last
  // beat reads zeros above the message.
  always_comb begin
    cap_pad              = '0;
    cap_pad[DIN_W-1:0]   = cap_q;
  end

  assign beat_data = DOUT_W'(cap_pad >> (cnt_q * DOUT_W));

  // Stream outputs depend only on registered state, never on m_ready_i, so
  // they hold naturally while the consumer stalls.
  assign m_valid_o = send;
  assign busy_o    = send;
  assign m_data_o  = send ? beat_data : '0;
  assign m_keep_o  = send ? (is_last ? LAST_KEEP : FULL_KEEP) : '0;
  assign m_last_o  = send && is_last;
  assign done_o    = done_q;
  assign overrun_o = ovr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;

    if (clear_i) begin
      ovr_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (msg_valid_i) begin
          cap_d   = msg_i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs && is_last) begin
          done_d = 1'b1;
          cnt_d  = '0;
          // A message arriving exactly as the last beat leaves is taken
          // straight away, giving back-to-back messages without a gap.
          if (msg_valid_i) begin
            cap_d   = msg_i;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (hs) begin
            cnt_d = cnt_q + 1'b1;
          end
          // Dropped message; set takes priority over a coincident clear.
          if (msg_valid_i) begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_hqc_msg_serializer.sv
// tb_hqc_msg_serializer
//   Three serializer instances (level 128 / 64-bit beats, level 192 / 128-bit
//   beats, level 256 / 64-bit beats) driven by directed scenarios. A byte-level
//   queue model predicts every beat; one compare process checks all outputs on
//   every falling edge, and literal expectations pin key beats.
module tb_hqc_msg_serializer;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  logic clk;
  logic rst_ni;

  logic [255:0] msg [3];
  logic         mv  [3];
  logic         clr [3];
  logic         rdy [3];

  logic [63:0]  d0, d2;
  logic [127:0] d1;
  logic [7:0]   k0, k2;
  logic [15:0]  k1;
  logic         ol [3];
  logic         ov [3];
  logic         ob [3];
  logic         odn[3];
  logic         oo [3];

  logic [127:0] od [3];
  logic [15:0]  ok [3];

  assign od[0] = {64'b0, d0};
  assign od[1] = d1;
  assign od[2] = {64'b0, d2};
  assign ok[0] = {8'b0, k0};
  assign ok[1] = k1;
  assign ok[2] = {8'b0, k2};

  int n_checks = 0;
  int n_errors = 0;

  int KB [3] = '{16, 24, 32};
  int BB [3] = '{8, 16, 8};

  beat_t mq [3][$];
  logic  edone [3];
  logic  eovr  [3];

  hqc_msg_serializer #(.PARAM_SECURITY(128), .DOUT_W(64)) u0 (
    .clk_i(clk), .rst_ni(rst_ni), .msg_i(msg[0][127:0]), .msg_valid_i(mv[0]),
    .clear_i(clr[0]), .m_data_o(d0), .m_keep_o(k0), .m_last_o(ol[0]),
    .m_valid_o(ov[0]), .m_ready_i(rdy[0]), .busy_o(ob[0]), .done_o(odn[0]),
    .overrun_o(oo[0]));

  hqc_msg_serializer #(.PARAM_SECURITY(192), .DOUT_W(128)) u1 (
    .clk_i(clk), .rst_ni(rst_ni), .msg_i(msg[1][191:0]), .msg_valid_i(mv[1]),
    .clear_i(clr[1]), .m_data_o(d1), .m_keep_o(k1), .m_last_o(ol[1]),
    .m_valid_o(ov[1]), .m_ready_i(rdy[1]), .busy_o(ob[1]), .done_o(odn[1]),
    .overrun_o(oo[1]));

  hqc_msg_serializer #(.PARAM_SECURITY(256), .DOUT_W(64)) u2 (
    .clk_i(clk), .rst_ni(rst_ni), .msg_i(msg[2]), .msg_valid_i(mv[2]),
    .clear_i(clr[2]), .m_data_o(d2), .m_keep_o(k2), .m_last_o(ol[2]),
    .m_valid_o(ov[2]), .m_ready_i(rdy[2]), .busy_o(ob[2]), .done_o(odn[2]),
    .overrun_o(oo[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: a message is a queue of beats. The head is on the bus; a handshake
  // pops it. A message is accepted when nothing is queued or the last beat
  // leaves in the same cycle; otherwise it is dropped and overrun sets.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        edone[i] = 1'b0;
        eovr[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        automatic bit    was_busy = (mq[i].size() != 0);
        automatic bit    last_out = 1'b0;
        automatic bit    accept;
        automatic beat_t b;
        automatic int    nb;
        automatic int    idx;
        edone[i] = 1'b0;
        if (was_busy && rdy[i]) begin
          b = mq[i].pop_front();
          last_out = b.l;
          edone[i] = b.l;
        end
        accept = mv[i] && (!was_busy || last_out);
        if (clr[i]) eovr[i] = 1'b0;
        if (mv[i] && !accept) eovr[i] = 1'b1;
        if (accept) begin
          nb = (KB[i] + BB[i] - 1) / BB[i];
          for (int bi = 0; bi < nb; bi++) begin
            b.d = '0;
            b.k = '0;
            for (int j = 0; j < BB[i]; j++) begin
              idx = bi * BB[i] + j;
              if (idx < KB[i]) begin
                b.d[8*j +: 8] = msg[i][8*idx +: 8];
                b.k[j] = 1'b1;
              end
            end
            b.l = (bi == nb - 1);
            mq[i].push_back(b);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      automatic bit v = (mq[i].size() != 0);
      chk($sformatf("u%0d.valid", i), 128'(ov[i]), 128'(v));
      chk($sformatf("u%0d.busy", i), 128'(ob[i]), 128'(v));
      chk($sformatf("u%0d.done", i), 128'(odn[i]), 128'(edone[i]));
      chk($sformatf("u%0d.overrun", i), 128'(oo[i]), 128'(eovr[i]));
      if (v) begin
        chk($sformatf("u%0d.data", i), od[i], mq[i][0].d);
        chk($sformatf("u%0d.keep", i), 128'(ok[i]), 128'(mq[i][0].k));
        chk($sformatf("u%0d.last", i), 128'(ol[i]), 128'(mq[i][0].l));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int i, input logic [7:0] base);
    msg[i] = '0;
    for (int j = 0; j < KB[i]; j++) msg[i][8*j +: 8] = base + 8'(j);
  endtask

  initial begin
    rst_ni = 1'b0;
    for (int i = 0; i < 3; i++) begin
      msg[i] = '0; mv[i] = 1'b0; clr[i] = 1'b0; rdy[i] = 1'b0;
    end

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst.u0.valid", 128'(ov[0]), 128'd0);
    chk("rst.u0.data", od[0], 128'd0);
    chk("rst.u1.keep", 128'(ok[1]), 128'd0);
    chk("rst.u2.busy", 128'(ob[2]), 128'd0);

    // Level 128, 64-bit beats; message arrives on the first cycle after release
    tick();
    rst_ni = 1'b1;
    fill(0, 8'h00);
    mv[0] = 1'b1; rdy[0] = 1'b1;
    tick();
    mv[0] = 1'b0;
    @(negedge clk);
    chk("s128.beat0", od[0], 128'h0706050403020100);
    chk("s128.keep0", 128'(k0), 128'hFF);
    chk("s128.last0", 128'(ol[0]), 128'd0);
    tick();
    @(negedge clk);
    chk("s128.beat1", od[0], 128'h0F0E0D0C0B0A0908);
    chk("s128.last1", 128'(ol[0]), 128'd1);
    tick();
    @(negedge clk);
    chk("s128.done", 128'(odn[0]), 128'd1);
    tick();
    @(negedge clk);
    chk("s128.done_once", 128'(odn[0]), 128'd0);

    // Level 192, 128-bit beats: partial last beat
    fill(1, 8'h10);
    mv[1] = 1'b1; rdy[1] = 1'b1;
    tick();
    mv[1] = 1'b0;
    @(negedge clk);
    chk("s192.beat0", od[1], 128'h1F1E1D1C1B1A19181716151413121110);
    tick();
    @(negedge clk);
    chk("s192.beat1", od[1], 128'h00000000000000002726252423222120);
    chk("s192.keep1", 128'(k1), 128'h00FF);
    chk("s192.last1", 128'(ol[1]), 128'd1);
    repeat (2) tick();

    // Level 256, 64-bit beats with a toggling consumer
    fill(2, 8'h40);
    mv[2] = 1'b1; rdy[2] = 1'b1;
    tick();
    mv[2] = 1'b0;
    @(negedge clk);
    chk("s256.beat0", od[2], 128'h4746454443424140);
    for (int c = 0; c < 12; c++) begin
      tick();
      rdy[2] = ~rdy[2];
    end
    rdy[2] = 1'b1;
    repeat (2) tick();

    // Overrun: second message during beat 0 is dropped
    rdy[0] = 1'b0;
    fill(0, 8'hA0);
    mv[0] = 1'b1;
    tick();
    fill(0, 8'hC0);
    tick();
    mv[0] = 1'b0;
    @(negedge clk);
    chk("ovr.set", 128'(oo[0]), 128'd1);
    chk("ovr.held", od[0], 128'hA7A6A5A4A3A2A1A0);
    rdy[0] = 1'b1;
    repeat (3) tick();
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    @(negedge clk);
    chk("ovr.clear", 128'(oo[0]), 128'd0);

    // Clear and overrun in the same cycle: set wins
    rdy[0] = 1'b0;
    fill(0, 8'h30);
    mv[0] = 1'b1;
    tick();
    clr[0] = 1'b1;
    tick();
    mv[0] = 1'b0; clr[0] = 1'b0;
    @(negedge clk);
    chk("ovr.setwins", 128'(oo[0]), 128'd1);
    rdy[0] = 1'b1;
    repeat (3) tick();
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;

    // Back-to-back: new message coincides with the last-beat handshake
    fill(0, 8'h50);
    mv[0] = 1'b1;
    tick();
    mv[0] = 1'b0;
    tick();
    fill(0, 8'h60);
    mv[0] = 1'b1;
    tick();
    mv[0] = 1'b0;
    @(negedge clk);
    chk("b2b.valid", 128'(ov[0]), 128'd1);
    chk("b2b.beat0", od[0], 128'h6766656463626160);
    chk("b2b.done", 128'(odn[0]), 128'd1);
    chk("b2b.ovr", 128'(oo[0]), 128'd0);
    repeat (4) tick();

    // Reset during beat 1 of 2
    fill(1, 8'h80);
    mv[1] = 1'b1; rdy[1] = 1'b0;
    tick();
    mv[1] = 1'b0;
    rdy[1] = 1'b1;
    tick();
    rdy[1] = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rstmid.valid", 128'(ov[1]), 128'd0);
    chk("rstmid.data", od[1], 128'd0);
    chk("rstmid.last", 128'(ol[1]), 128'd0);
    chk("rstmid.keep", 128'(ok[1]), 128'd0);
    tick();
    rst_ni = 1'b1;
    rdy[1] = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rstmid.quiet", 128'(ov[1]), 128'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
